max7219_frame_tx: RTL and testbench
===================================

Name: max7219_frame_tx

Overview:
- SPI serializer for the MAX7219 LED-matrix driver. Sits directly downstream of the face-pattern sequencer.
- Takes one 16-bit register-write word per handshake: address in [11:8], data in [7:0].
- Shifts the word MSB-first with CS held low for the whole frame, then raises CS so the MAX7219 latches it.
- Replaces the 8-bit-per-CS transfer path, which does not produce valid MAX7219 frames.

Parameters:
CLK_DIV, 4, sclk half-period in clk cycles (>=1); sclk = f_clk/(2*CLK_DIV)
CS_HOLD, 2, clk cycles CS stays low after the last sclk falling edge (>=1)
CS_GAP, 4, clk cycles CS stays high after the frame before busy drops (>=1)

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  asynchronous, active-low reset
start  in  1  request to send data_in; sampled only when idle
data_in  in  16  frame word, transmitted bit 15 first; bits [15:12] sent as given
busy  out  1  high from the acceptance edge until the frame, hold and gap complete
done  out  1  one-cycle pulse at frame completion
sclk  out  1  SPI clock, idle low
mosi  out  1  serial data, changes only while sclk is low
cs  out  1  LOAD/chip select, idle high, low during the frame

Behaviour:
- Reset (reset=0, async): cs=1, sclk=0, mosi=0, busy=0, done=0; FSM returns to IDLE; all counters cleared.
- States: IDLE -> LOW -> HIGH -> (LOW ... 16 bits) -> HOLD -> GAP -> IDLE.
- IDLE:
  - done=0.
  - Edge with start=1: latch data_in into shift register; cs<=0; mosi<=data_in[15]; busy<=1; bit_cnt<=15; go to LOW.
- LOW:
  - sclk=0 for CLK_DIV cycles, then sclk<=1 and go to HIGH.
  - Rising sclk edge is the MAX7219 sample point; mosi is stable for the full CLK_DIV low phase before it.
- HIGH: sclk=1 for CLK_DIV cycles, then sclk<=0.
  - If bit_cnt>0: shift register left, mosi<=next bit, bit_cnt-1, go to LOW.
  - If bit_cnt==0: go to HOLD.
- HOLD: cs low, sclk low for CS_HOLD cycles, then cs<=1 (rising edge latches the word); go to GAP.
- GAP: cs high for CS_GAP cycles, then busy<=0, done<=1 for exactly one cycle; go to IDLE.
- Frame length: exactly 16 rising sclk edges per frame.
- Latency: busy is high for exactly 32*CLK_DIV + CS_HOLD + CS_GAP cycles (defaults: 134).
- Handshake:
  - start while busy=1 is ignored; it is not queued.
  - data_in is sampled only on the acceptance edge; later changes do not affect the frame in flight.
- Back-to-back: if start is high in the cycle done=1, the next frame is accepted on the following edge. Minimum cs-high time between frames = CS_GAP+1 cycles.
- Reset mid-frame: outputs go to idle values immediately. The cs rise may latch a partial word in the MAX7219; the upstream sequencer re-runs its init sequence after reset.
- Counters: div_cnt sized clog2(max(CLK_DIV,CS_HOLD,CS_GAP)+1); bit_cnt 4 bits, no wrap past 0.

Decomposition:
- Shared package max7219_pkg:
  - Register addresses: NOOP=0x0, DIGIT0..7=0x1..0x8, DECODE=0x9, INTENSITY=0xA, SCAN_LIMIT=0xB, SHUTDOWN=0xC, TEST=0xF.
  - FRAME_W=16.
  - FSM state encoding.
- One sub-module, max7219_tick_cnt: loadable down-counter that asserts a terminal flag. Reused for the LOW, HIGH, HOLD and GAP phase timing.

Test Plan:
1. Reset: hold reset=0 with random start/data_in -> cs=1, sclk=0, mosi=0, busy=0, done=0 throughout.
2. Single frame, data_in=0x0C01, defaults -> 16 sclk rises; mosi at the rises = 0000110000000001; cs low through the last fall + 2 cycles; busy high 134 cycles; one done pulse.
3. Start during busy: frame 0x0C01, then start with 0x0A0F at cycle 40 -> only 0x0C01 on mosi; exactly one done pulse.
4. start held high, data_in switched 0x0107 -> 0x0255 on the done cycle -> two frames 0x0107, 0x0255; cs high exactly 5 cycles between them.
5. reset=0 during bit 8 of 0xFFFF -> cs=1, sclk=0, busy=0 in the same cycle. After release, 0x0F00 transmits correctly with 16 rises.
6. CLK_DIV=1, CS_HOLD=1, CS_GAP=1, data_in=0xA5A5 -> sclk period 2 cycles; mosi 1010010110100101; busy 34 cycles.

Source files
------------

// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 frame serializer: register map,
// frame width, FSM state encoding and a small sizing helper.
package max7219_pkg;

  // One MAX7219 register write: 4 don't-care bits, 4 address bits, 8 data bits.
  localparam int FRAME_W = 16;

  // MAX7219 register addresses (frame bits [11:8]).
  localparam logic [3:0] REG_NOOP       = 4'h0;
  localparam logic [3:0] REG_DIGIT0     = 4'h1;
  localparam logic [3:0] REG_DIGIT1     = 4'h2;
  localparam logic [3:0] REG_DIGIT2     = 4'h3;
  localparam logic [3:0] REG_DIGIT3     = 4'h4;
  localparam logic [3:0] REG_DIGIT4     = 4'h5;
  localparam logic [3:0] REG_DIGIT5     = 4'h6;
  localparam logic [3:0] REG_DIGIT6     = 4'h7;
  localparam logic [3:0] REG_DIGIT7     = 4'h8;
  localparam logic [3:0] REG_DECODE     = 4'h9;
  localparam logic [3:0] REG_INTENSITY  = 4'hA;
  localparam logic [3:0] REG_SCAN_LIMIT = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN   = 4'hC;
  localparam logic [3:0] REG_TEST       = 4'hF;

  // Serializer FSM states.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOW  = 3'd1;
  localparam logic [2:0] ST_HIGH = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  // Largest of three phase lengths; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/max7219_tick_cnt.sv
// Loadable down-counter used to time every phase of the frame.
// Loading N-1 makes o_tc assert on the N-th cycle after the load edge,
// so a phase entered with a load lasts exactly N clk cycles.
module max7219_tick_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/max7219_frame_tx.sv
// SPI serializer for the MAX7219: one 16-bit register write per start
// handshake, shifted MSB-first with cs low for the whole frame, then cs is
// raised so the MAX7219 latches the word. Parameters must all be >= 1.
module max7219_frame_tx
  import max7219_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_HOLD = 2,
  parameter int CS_GAP  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [FRAME_W-1:0] data_in,
  output logic               busy,
  output logic               done,
  output logic               sclk,
  output logic               mosi,
  output logic               cs
);

  localparam int CNT_W = $clog2(max3(CLK_DIV, CS_HOLD, CS_GAP) + 1);
  localparam logic [CNT_W-1:0] LD_DIV  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LD_HOLD = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_GAP  = CNT_W'(CS_GAP - 1);
  localparam logic [3:0]       LAST_BIT = 4'(FRAME_W - 1);

  logic [2:0]         r_state;
  logic [FRAME_W-2:0] r_shift;    // bits still to send; the MSB goes out at acceptance
  logic [3:0]         r_bit_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_sclk;
  logic               r_mosi;
  logic               r_cs;

  logic               w_load;
  logic [CNT_W-1:0]   w_load_val;
  logic               w_tc;

  max7219_tick_cnt #(.W(CNT_W)) u_tick (
    .clk        (clk),
    .i_rst_n    (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tc       (w_tc)
  );

  // Reload the phase counter on every transition with the next phase's length.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load     = 1'b1;
          w_load_val = LD_DIV;
        end
      end
      ST_LOW: begin
        if (w_tc) begin
          w_load     = 1'b1;
          w_load_val = LD_DIV;
        end
      end
      ST_HIGH: begin
        if (w_tc) begin
          w_load     = 1'b1;
          w_load_val = (r_bit_cnt != 4'd0) ? LD_DIV : LD_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_tc) begin
          w_load     = 1'b1;
          w_load_val = LD_GAP;
        end
      end
      default: begin
        w_load     = 1'b0;
        w_load_val = '0;
      end
    endcase
  end

  // Frame sequencer: accept, 16 low/high sclk phases, cs hold, cs gap, done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= 4'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs      <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_shift   <= data_in[FRAME_W-2:0];
            r_mosi    <= data_in[FRAME_W-1];
            r_cs      <= 1'b0;
            r_busy    <= 1'b1;
            r_bit_cnt <= LAST_BIT;
            r_state   <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (w_tc) begin
            r_sclk  <= 1'b1;
            r_state <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (w_tc) begin
            r_sclk <= 1'b0;
            if (r_bit_cnt != 4'd0) begin
              // next bit is presented together with the falling sclk edge
              r_mosi    <= r_shift[FRAME_W-2];
              r_shift   <= {r_shift[FRAME_W-3:0], 1'b0};
              r_bit_cnt <= r_bit_cnt - 4'd1;
              r_state   <= ST_LOW;
            end else begin
              r_mosi  <= 1'b0;
              r_state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (w_tc) begin
            r_cs    <= 1'b1;   // rising LOAD latches the word in the MAX7219
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (w_tc) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sclk = r_sclk;
  assign mosi = r_mosi;
  assign cs   = r_cs;

endmodule

// File: tb/tb_max7219_frame_tx.sv
// Directed bench for max7219_frame_tx: default-parameter instance (index 0)
// and a fastest-timing instance (index 1). Expected words are queued when a
// frame is launched and popped when the monitor sees cs rise.
module tb_max7219_frame_tx;
  import max7219_pkg::*;

  localparam int EXP_DIV [2] = '{4, 1};
  localparam int EXP_HOLD[2] = '{2, 1};
  localparam int EXP_GAP [2] = '{4, 1};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] data_in = 16'h0;
  logic        busy, done, sclk, mosi, cs;
  logic        b_start = 1'b0;
  logic [15:0] b_data_in = 16'h0;
  logic        b_busy, b_done, b_sclk, b_mosi, b_cs;

  always #5 clk = ~clk;

  max7219_frame_tx #(.CLK_DIV(4), .CS_HOLD(2), .CS_GAP(4)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .busy(busy), .done(done), .sclk(sclk), .mosi(mosi), .cs(cs)
  );

  max7219_frame_tx #(.CLK_DIV(1), .CS_HOLD(1), .CS_GAP(1)) u_dut_b (
    .clk(clk), .reset(reset), .start(b_start), .data_in(b_data_in),
    .busy(b_busy), .done(b_done), .sclk(b_sclk), .mosi(b_mosi), .cs(b_cs)
  );

  logic [1:0] m_sclk, m_mosi, m_cs, m_busy, m_done;
  assign m_sclk = {b_sclk, sclk};
  assign m_mosi = {b_mosi, mosi};
  assign m_cs   = {b_cs, cs};
  assign m_busy = {b_busy, busy};
  assign m_done = {b_done, done};

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [15:0] exp_q[$];
  int n_done[2] = '{0, 0};
  int last_gap[2] = '{0, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor state per instance
  logic        prev_sclk[2], prev_cs[2], prev_busy[2], prev_done[2];
  logic [15:0] word[2];
  int          nrise[2], since_rise[2], since_fall[2];
  int          busy_len[2], done_len[2], cs_high[2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        prev_sclk[k] = 1'b0; prev_cs[k] = 1'b1; prev_busy[k] = 1'b0; prev_done[k] = 1'b0;
        word[k] = 16'h0; nrise[k] = 0; since_rise[k] = 0; since_fall[k] = 0;
        busy_len[k] = 0; done_len[k] = 0; cs_high[k] = 0;
      end else begin
        since_rise[k]++;
        since_fall[k]++;
        if (m_sclk[k] && !prev_sclk[k]) begin
          if (nrise[k] > 0)
            check($sformatf("sclk_period_d%0d", k), since_rise[k], 2 * EXP_DIV[k]);
          word[k] = {word[k][14:0], m_mosi[k]};
          nrise[k]++;
          since_rise[k] = 0;
        end
        if (!m_sclk[k] && prev_sclk[k]) since_fall[k] = 0;
        if (m_cs[k]) cs_high[k]++;
        if (!m_cs[k] && prev_cs[k]) begin
          last_gap[k] = cs_high[k];
          cs_high[k] = 0;
          nrise[k] = 0;
          word[k] = 16'h0;
        end
        if (m_cs[k] && !prev_cs[k]) begin
          check($sformatf("cs_hold_d%0d", k), since_fall[k], EXP_HOLD[k]);
          check($sformatf("sclk_rises_d%0d", k), nrise[k], 16);
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $error("FAIL unexpected_frame_d%0d observed=0x%04h expected=none", k, word[k]);
          end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            $display("frame dut%0d word=0x%04h expected=0x%04h rises=%0d", k, word[k], e, nrise[k]);
            check($sformatf("frame_word_d%0d", k), word[k], e);
          end
        end
        if (m_busy[k]) busy_len[k]++;
        else if (prev_busy[k]) begin
          check($sformatf("busy_len_d%0d", k), busy_len[k],
                32 * EXP_DIV[k] + EXP_HOLD[k] + EXP_GAP[k]);
          busy_len[k] = 0;
        end
        if (m_done[k]) begin
          if (!prev_done[k]) n_done[k]++;
          done_len[k]++;
        end else if (prev_done[k]) begin
          check($sformatf("done_width_d%0d", k), done_len[k], 1);
          done_len[k] = 0;
        end
        prev_sclk[k] = m_sclk[k];
        prev_cs[k]   = m_cs[k];
        prev_busy[k] = m_busy[k];
        prev_done[k] = m_done[k];
      end
    end
  end

  task automatic send(input int k, input logic [15:0] w, input bit expect_frame);
    @(posedge clk);
    #1;
    if (k == 0) begin start = 1'b1; data_in = w; end
    else begin b_start = 1'b1; b_data_in = w; end
    if (expect_frame) exp_q.push_back(w);
    @(posedge clk);
    #1;
    start = 1'b0;
    b_start = 1'b0;
    data_in = 16'($urandom);
    b_data_in = 16'($urandom);
    check($sformatf("accept_busy_d%0d", k), {31'b0, m_busy[k]}, 1);
  endtask

  task automatic wait_done(input int k, input int maxc);
    bit got;
    got = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (m_done[k]) begin
        got = 1'b1;
        break;
      end
    end
    check($sformatf("done_seen_d%0d", k), {31'b0, got}, 1);
  endtask

  initial begin
    int d0;
    logic [15:0] w_shutdown;
    w_shutdown = {4'h0, REG_SHUTDOWN, 8'h01};

    // 1: reset held with random inputs
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      start = 1'($urandom);
      data_in = 16'($urandom);
      b_start = 1'($urandom);
      b_data_in = 16'($urandom);
      @(negedge clk);
      check("reset_idle_a", {27'b0, cs, sclk, mosi, busy, done}, 32'h10);
      check("reset_idle_b", {27'b0, b_cs, b_sclk, b_mosi, b_busy, b_done}, 32'h10);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    b_start = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);

    // 2: single frame 0x0C01
    d0 = n_done[0];
    send(0, w_shutdown, 1'b1);
    wait_done(0, 300);
    repeat (5) @(negedge clk);
    check("t2_done_count", n_done[0] - d0, 1);

    // 3: start while busy is ignored
    d0 = n_done[0];
    send(0, 16'h0C01, 1'b1);
    repeat (39) @(posedge clk);
    #1;
    start = 1'b1;
    data_in = 16'h0A0F;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(0, 300);
    repeat (160) @(negedge clk);
    check("t3_done_count", n_done[0] - d0, 1);
    check("t3_queue_empty", exp_q.size(), 0);

    // 4: back-to-back with start held high
    d0 = n_done[0];
    @(posedge clk);
    #1;
    start = 1'b1;
    data_in = 16'h0107;
    exp_q.push_back(16'h0107);
    wait_done(0, 300);
    data_in = 16'h0255;
    exp_q.push_back(16'h0255);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("t4_reaccept_busy", {31'b0, busy}, 1);
    wait_done(0, 300);
    repeat (3) @(negedge clk);
    check("t4_done_count", n_done[0] - d0, 2);
    check("t4_cs_gap", last_gap[0], EXP_GAP[0] + 1);

    // 5: reset in the middle of bit 8, then a clean frame
    send(0, 16'hFFFF, 1'b0);
    repeat (60) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("t5_reset_outputs", {27'b0, cs, sclk, mosi, busy, done}, 32'h10);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    d0 = n_done[0];
    send(0, 16'h0F00, 1'b1);
    wait_done(0, 300);
    repeat (3) @(negedge clk);
    check("t5_done_count", n_done[0] - d0, 1);

    // 6: fastest timing instance
    d0 = n_done[1];
    send(1, 16'hA5A5, 1'b1);
    wait_done(1, 100);
    repeat (5) @(negedge clk);
    check("t6_done_count", n_done[1] - d0, 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
